// File: rtl/rom_burst_reader.sv
// Parametrised ROM with a burst read engine.
// Ports: clk, rst (sync, active-high); req_valid/req_ready with req_addr,
// req_len (beats-1), req_wrap; rd_valid/rd_ready with rd_data, rd_addr, rd_last.
module rom_burst_reader #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 4,
    parameter int    LEN_W     = 4,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              req_wrap,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_last
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    logic [DATA_W-1:0] mem [DEPTH];

    // Default image: the address bits repeated across the word.
    function automatic logic [DATA_W-1:0] default_word(input int unsigned a);
        logic [DATA_W-1:0] w;
        logic [ADDR_W-1:0] ab;
        ab = ADDR_W'(a);
        for (int i = 0; i < DATA_W; i++) begin
            w[i] = ab[i % ADDR_W];
        end
        return w;
    endfunction

    generate
        for (genvar a = 0; a < DEPTH; a++) begin : g_word
            assign mem[a] = default_word(a);
        end
    endgenerate

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] next_ptr;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  next_remaining;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] next_wrap_mask;
    logic [ADDR_W-1:0] accept_mask;
    logic [ADDR_W-1:0] ptr_step;
    logic [LEN_W:0]    len_plus1;
    logic              len_pow2;
    logic              advance;
    logic              accept;
    logic              load;
    logic              drop;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign advance   = !rd_valid || rd_ready;

    // Burst of len+1 beats wraps only when that count is a power of two.
    assign len_plus1   = {1'b0, req_len} + (LEN_W + 1)'(1);
    assign len_pow2    = (len_plus1 & {1'b0, req_len}) == '0;
    assign accept_mask = (req_wrap && len_pow2) ? ADDR_W'(req_len) : '0;

    // Low bits under the mask count modulo the block; upper bits stay put.
    assign ptr_step = (wrap_mask != '0)
                    ? ((ptr & ~wrap_mask) | ((ptr + ADDR_W'(1)) & wrap_mask))
                    : ptr + ADDR_W'(1);

    always_comb begin
        next_state     = state;
        next_ptr       = ptr;
        next_remaining = remaining;
        next_wrap_mask = wrap_mask;
        load           = 1'b0;
        drop           = 1'b0;
        unique case (state)
            IDLE: begin
                drop = advance;
                if (accept) begin
                    next_state     = BURST;
                    next_ptr       = req_addr;
                    next_remaining = req_len;
                    next_wrap_mask = accept_mask;
                end
            end
            BURST: begin
                if (advance) begin
                    load = 1'b1;
                    if (remaining == '0) begin
                        next_state = IDLE;
                    end else begin
                        next_remaining = remaining - LEN_W'(1);
                        next_ptr       = ptr_step;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            wrap_mask <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            rd_data   <= '0;
            rd_addr   <= '0;
        end else begin
            state     <= next_state;
            ptr       <= next_ptr;
            remaining <= next_remaining;
            wrap_mask <= next_wrap_mask;
            if (load) begin
                rd_data  <= mem[ptr];
                rd_addr  <= ptr;
                rd_valid <= 1'b1;
                rd_last  <= (remaining == '0);
            end else if (drop) begin
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_burst_reader.sv
// Self-checking bench for rom_burst_reader: directed table, corner
// sequences and randomized bursts against a beat-list reference model.
module tb_rom_burst_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_addr;
    logic [3:0]  req_len;
    logic        req_wrap;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic [3:0]  rd_addr;
    logic        rd_last;

    rom_burst_reader dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wrap  (req_wrap),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_addr   (rd_addr),
        .rd_last   (rd_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [15:0] d;
        logic        last;
    } beat_t;

    typedef struct {
        logic [3:0]  addr;
        logic [3:0]  len;
        logic        wrap;
        logic [31:0] seq;
    } vec_t;

    beat_t       expq[$];
    vec_t        tbl[8];
    int          tests = 0;
    int          fails = 0;
    int          rdy_mode = 0;
    int          beats = 0;
    bit          prev_stall = 0;
    logic [21:0] held;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic observe();
        beat_t e;
        if (rd_valid && rd_ready) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beat: got addr %0h data %h, required none",
                         rd_addr, rd_data);
            end else begin
                e = expq.pop_front();
                chk("beat", 64'({rd_last, rd_addr, rd_data}),
                    64'({e.last, e.a, e.d}));
            end
            beats++;
        end
        if (prev_stall)
            chk("stall_hold", 64'({rd_valid, rd_last, rd_addr, rd_data}),
                64'(held));
        prev_stall = rd_valid && !rd_ready && !rst;
        held = {rd_valid, rd_last, rd_addr, rd_data};
    endtask

    task automatic tick();
        if (rdy_mode == 0) rd_ready = 1'b1;
        else if (rdy_mode == 1) rd_ready = 1'($urandom_range(0, 1));
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] a, input logic [3:0] l,
                            input logic w);
        int n = 0;
        req_addr  = a;
        req_len   = l;
        req_wrap  = w;
        req_valid = 1'b1;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) chk("req_timeout", 64'(req_ready), 64'(1));
        else tick();
        req_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (expq.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        if (expq.size() != 0) chk("drain_timeout", 64'(expq.size()), 64'(0));
    endtask

    task automatic wait_vis(input logic [3:0] a);
        int n = 0;
        while (!(rd_valid && rd_addr == a) && n < 100) begin
            tick();
            n++;
        end
        chk("wait_vis", 64'({rd_valid, rd_addr}), 64'({1'b1, a}));
    endtask

    // Expected beats from the table's packed address list.
    task automatic push_seq(input logic [31:0] seq, input int len);
        beat_t b;
        for (int i = 0; i <= len; i++) begin
            b.a    = seq[4*i +: 4];
            b.d    = 16'(b.a) * 16'h1111;
            b.last = (i == len);
            expq.push_back(b);
        end
    endtask

    // Reference: wrap inside the aligned block of n words, else count mod 16.
    task automatic model_push(input int a, input int l, input int w);
        int    n;
        int    base;
        int    x;
        bit    blk;
        beat_t b;
        n    = l + 1;
        blk  = (w != 0) && ((n & (n - 1)) == 0);
        base = blk ? (a / n) * n : 0;
        for (int i = 0; i < n; i++) begin
            x      = blk ? base + ((a - base + i) % n) : (a + i) % 16;
            b.a    = 4'(x);
            b.d    = 16'(x * 'h1111);
            b.last = (i == n - 1);
            expq.push_back(b);
        end
    endtask

    initial begin
        tbl[0] = '{addr: 4'd0,  len: 4'd0, wrap: 1'b0, seq: 32'h0};
        tbl[1] = '{addr: 4'd14, len: 4'd3, wrap: 1'b0, seq: 32'h10FE};
        tbl[2] = '{addr: 4'd6,  len: 4'd3, wrap: 1'b1, seq: 32'h5476};
        tbl[3] = '{addr: 4'd5,  len: 4'd2, wrap: 1'b1, seq: 32'h765};
        tbl[4] = '{addr: 4'd9,  len: 4'd1, wrap: 1'b1, seq: 32'h89};
        tbl[5] = '{addr: 4'd3,  len: 4'd7, wrap: 1'b1, seq: 32'h21076543};
        tbl[6] = '{addr: 4'd12, len: 4'd4, wrap: 1'b1, seq: 32'h0FEDC};
        tbl[7] = '{addr: 4'd7,  len: 4'd0, wrap: 1'b1, seq: 32'h7};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wrap  = 1'b0;
        rd_ready  = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_valid", 64'(rd_valid), 64'(0));
        chk("rst_last", 64'(rd_last), 64'(0));
        chk("rst_data", 64'(rd_data), 64'(0));
        chk("rst_addr", 64'(rd_addr), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_rst", 64'(req_ready), 64'(1));

        for (int i = 0; i < 8; i++) begin
            send_req(tbl[i].addr, tbl[i].len, tbl[i].wrap);
            push_seq(tbl[i].seq, int'(tbl[i].len));
            chk("lat_none", 64'(rd_valid), 64'(0));
            tick();
            chk("lat_first", 64'(rd_valid), 64'(1));
            chk("ready_during", 64'(req_ready), 64'(tbl[i].len == 0));
            drain(100);
        end

        send_req(4'd8, 4'd7, 1'b0);
        model_push(8, 7, 0);
        wait_vis(4'd9);
        rdy_mode = 2;
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", 64'(rd_data), 64'(16'h9999));
            tick();
        end
        chk("stall_data_end", 64'(rd_data), 64'(16'h9999));
        rdy_mode = 0;
        beats = 0;
        drain(100);
        chk("stall_beats", 64'(beats), 64'(7));

        send_req(4'd0, 4'd15, 1'b0);
        model_push(0, 15, 0);
        wait_vis(4'd3);
        rst = 1'b1;
        tick();
        chk("abort_valid", 64'(rd_valid), 64'(0));
        chk("abort_data", 64'(rd_data), 64'(0));
        chk("abort_addr", 64'(rd_addr), 64'(0));
        chk("abort_ready", 64'(req_ready), 64'(0));
        expq.delete();
        rst = 1'b0;
        #1;
        chk("abort_ready_rel", 64'(req_ready), 64'(1));
        send_req(4'd2, 4'd0, 1'b0);
        push_seq(32'h2, 0);
        drain(100);

        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int a;
            int l;
            int w;
            a = $urandom_range(0, 15);
            l = $urandom_range(0, 15);
            w = $urandom_range(0, 1);
            send_req(4'(a), 4'(l), 1'(w));
            model_push(a, l, w);
            if ($urandom_range(0, 3) == 0) tick();
        end
        drain(2000);
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) tick();
        chk("final_idle", 64'(rd_valid), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
